jogo_sequencia_param: RTL

Parametrised memory-sequence game core for the Genius-style game. It generalises the fixed 4-button, 4/16-round circuit in three ways: button count, sequence depth and all time constants are parameters. It also adds LED playback of the stored sequence before each round, multi-button error detection, and a round counter. It sits between the debounced button inputs and the board LEDs/7-segment debug logic.

---
 rtl/jogo_sequencia_param.sv | 212 +++++++++++++++++++++
 1 files changed

// File: rtl/jogo_sequencia_param.sv
// rtl/jogo_sequencia_param.sv - parametrised memory-sequence game core
//
// Genius-style game core: plays the stored sequence back on leds, checks the
// player's repetition, records one new symbol per round and ends in a win,
// a wrong-press loss or a timeout loss.
//
// Ports:
//   clock         rising-edge system clock
//   reset         asynchronous active-low reset
//   jogar         start request, acts on its rising edge
//   botoes        debounced button levels, one-hot symbols
//   configuracao  [0] demo round limit, [1] timeout enable; latched at start
//   ganhou        game won (final state)
//   perdeu        game lost by wrong press, multi-button press or timeout
//   timeout       loss was caused by timeout
//   pronto        any final state
//   leds          playback symbol
//   rodada        number of stored symbols
//   db_estado     current state code
//
// Build option: ECO_LEDS_EN echoes botoes on leds while waiting for a press.

module jogo_sequencia_param #(
   parameter int N_BOTOES       = 4,
   parameter int PROFUNDIDADE   = 16,
   parameter int RODADAS_DEMO   = 4,
   parameter int CICLOS_EXIBE   = 1000,
   parameter int CICLOS_APAGADO = 250,
   parameter int CICLOS_TIMEOUT = 5000
) (
   input  logic                                clock,
   input  logic                                reset,
   input  logic                                jogar,
   input  logic [N_BOTOES-1:0]                 botoes,
   input  logic [1:0]                          configuracao,
   output logic                                ganhou,
   output logic                                perdeu,
   output logic                                timeout,
   output logic                                pronto,
   output logic [N_BOTOES-1:0]                 leds,
   output logic [$clog2(PROFUNDIDADE+1)-1:0]   rodada,
   output logic [3:0]                          db_estado
);

   localparam int RW     = $clog2(PROFUNDIDADE + 1);
   localparam int AW     = $clog2(PROFUNDIDADE);
   localparam int CMAX_A = (CICLOS_EXIBE > CICLOS_APAGADO) ? CICLOS_EXIBE : CICLOS_APAGADO;
   localparam int CMAX   = (CMAX_A > CICLOS_TIMEOUT) ? CMAX_A : CICLOS_TIMEOUT;
   localparam int CW     = $clog2(CMAX + 1);

   typedef enum logic [3:0] {
      INICIAL     = 4'h0,
      PREPARA     = 4'h1,
      EXIBE       = 4'h2,
      APAGA       = 4'h3,
      ESPERA      = 4'h4,
      COMPARA     = 4'h5,
      ESPERA_NOVA = 4'h6,
      GRAVA       = 4'h7,
      PROXIMA     = 4'h8,
      FIM_GANHOU  = 4'h9,
      FIM_PERDEU  = 4'hA,
      FIM_TIMEOUT = 4'hB
   } estado_t;

   estado_t             estado, prox;
   logic                jogar_q;
   logic [N_BOTOES-1:0] botoes_q;
   logic [N_BOTOES-1:0] captura;
   logic [1:0]          cfg;
   logic [RW-1:0]       indice;
   logic [RW-1:0]       limite;
   logic [CW-1:0]       cnt;
   logic [N_BOTOES-1:0] mem [PROFUNDIDADE];

   logic jogar_borda, aguardando, press, um_quente, simbolo_ok, expirou;
   logic inc_idx, clr_idx, grava, clr_jogo, lat_cfg;

   assign jogar_borda = jogar & ~jogar_q;
   assign aguardando  = (estado == ESPERA) || (estado == ESPERA_NOVA);
   // A press needs an all-released sample first, so a button held across a
   // state change is never taken as a new press.
   assign press       = aguardando && (botoes_q == '0) && (botoes != '0);
   assign um_quente   = (captura & (captura - 1'b1)) == '0;
   assign simbolo_ok  = um_quente && (captura == mem[indice[AW-1:0]]);
   assign expirou     = cfg[1] && (cnt == CW'(CICLOS_TIMEOUT - 1));
   assign limite      = cfg[0] ? RW'(RODADAS_DEMO) : RW'(PROFUNDIDADE);

   always_comb begin
      prox     = estado;
      inc_idx  = 1'b0;
      clr_idx  = 1'b0;
      grava    = 1'b0;
      clr_jogo = 1'b0;
      lat_cfg  = 1'b0;
      case (estado)
         INICIAL, FIM_GANHOU, FIM_PERDEU, FIM_TIMEOUT: begin
            if (jogar_borda) begin
               prox     = PREPARA;
               clr_jogo = 1'b1;
            end
         end
         PREPARA: begin
            lat_cfg = 1'b1;
            prox    = (rodada != '0) ? EXIBE : ESPERA_NOVA;
         end
         EXIBE: begin
            if (cnt == CW'(CICLOS_EXIBE - 1)) prox = APAGA;
         end
         APAGA: begin
            if (cnt == CW'(CICLOS_APAGADO - 1)) begin
               if (indice + 1'b1 < rodada) begin
                  inc_idx = 1'b1;
                  prox    = EXIBE;
               end else begin
                  clr_idx = 1'b1;
                  prox    = ESPERA;
               end
            end
         end
         // Press is checked before expiry: a press on the last cycle wins.
         ESPERA: begin
            if (press)        prox = COMPARA;
            else if (expirou) prox = FIM_TIMEOUT;
         end
         COMPARA: begin
            if (!simbolo_ok) begin
               prox = FIM_PERDEU;
            end else begin
               inc_idx = 1'b1;
               prox    = (indice + 1'b1 == rodada) ? ESPERA_NOVA : ESPERA;
            end
         end
         ESPERA_NOVA: begin
            if (press)        prox = GRAVA;
            else if (expirou) prox = FIM_TIMEOUT;
         end
         GRAVA: begin
            if (!um_quente) begin
               prox = FIM_PERDEU;
            end else begin
               grava = 1'b1;
               prox  = PROXIMA;
            end
         end
         PROXIMA: begin
            if (rodada == limite) begin
               prox = FIM_GANHOU;
            end else begin
               clr_idx = 1'b1;
               prox    = EXIBE;
            end
         end
         default: prox = INICIAL;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         estado   <= INICIAL;
         jogar_q  <= 1'b0;
         botoes_q <= '0;
         captura  <= '0;
         cfg      <= '0;
         cnt      <= '0;
         rodada   <= '0;
         indice   <= '0;
      end else begin
         estado   <= prox;
         jogar_q  <= jogar;
         botoes_q <= botoes;
         if (press)   captura <= botoes;
         if (lat_cfg) cfg     <= configuracao;
         // One counter serves display, dark and idle timing: it restarts on
         // every state change, which also covers "clear on press".
         cnt <= (prox != estado) ? '0 : cnt + 1'b1;
         if (clr_jogo) begin
            rodada <= '0;
            indice <= '0;
         end else begin
            if (grava)        rodada <= rodada + 1'b1;
            if (clr_idx)      indice <= '0;
            else if (inc_idx) indice <= indice + 1'b1;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (grava) mem[rodada[AW-1:0]] <= captura;
   end

   always_comb begin
      leds = '0;
      if (estado == EXIBE) begin
         leds = mem[indice[AW-1:0]];
      end
`ifdef ECO_LEDS_EN
      else if (aguardando) begin
         leds = botoes;
      end
`else
`endif
   end

   assign ganhou    = (estado == FIM_GANHOU);
   assign perdeu    = (estado == FIM_PERDEU) || (estado == FIM_TIMEOUT);
   assign timeout   = (estado == FIM_TIMEOUT);
   assign pronto    = (estado == FIM_GANHOU) || (estado == FIM_PERDEU) ||
                      (estado == FIM_TIMEOUT);
   assign db_estado = estado;

endmodule
